// File: rtl/ga_vd_window_buff.sv
// ga_vd_window_buff: windowed store of (v_vec, d) samples with indexed read-back.
// Supports fill-once and sliding-window modes. Config is latched on the ga_enable rising edge.
module ga_vd_window_buff #(
   parameter int DATA_W  = 32,
   parameter int M_MAX   = 8,
   parameter int B_MAX   = 16,
   parameter int M_MAX_W = $clog2(M_MAX + 1),
   parameter int B_MAX_W = $clog2(B_MAX + 1)
) (
   input  logic                    clk,
   input  logic                    sw_rst,
   input  logic                    ga_enable,
   input  logic [M_MAX_W-1:0]      cnfg_m,
   input  logic [B_MAX_W-1:0]      cnfg_b,
   input  logic                    cnfg_mode,
   input  logic                    i_valid_pls,
   input  logic [DATA_W*M_MAX-1:0] i_v_vec_flat,
   input  logic [DATA_W-1:0]       i_d,
   input  logic                    rd_req,
   input  logic [B_MAX_W-1:0]      rd_idx,
   output logic                    o_rd_valid,
   output logic [DATA_W*M_MAX-1:0] o_v_vec_flat,
   output logic [DATA_W-1:0]       o_d,
   output logic                    o_rd_err,
   output logic                    o_ready,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [B_MAX_W-1:0]      o_fullness,
   output logic [31:0]             o_wr_counter,
   output logic [31:0]             o_drop_counter
);

   localparam int unsigned VEC_W = DATA_W * M_MAX;
   localparam int unsigned PTR_W = (B_MAX > 1) ? $clog2(B_MAX) : 1;
   localparam int unsigned SUM_W = B_MAX_W + 1;

   logic [VEC_W-1:0]  mem_v [B_MAX];
   logic [DATA_W-1:0] mem_d [B_MAX];

   logic               en_q;
   logic [M_MAX_W-1:0] m_q, m_clamp, m_n;
   logic [B_MAX_W-1:0] b_q, b_clamp, b_n;
   logic               mode_q, mode_n;
   logic [PTR_W-1:0]   wr_ptr, wr_ptr_n, oldest, oldest_n, slot;
   logic [B_MAX_W-1:0] fullness_n;
   logic [SUM_W-1:0]   slot_sum;
   logic [VEC_W-1:0]   wr_vec;
   logic               rise, fall, full_now, wr_acc, drop, rd, rd_err;
   logic               full_n, ready_n;

   // Enable edges, write/read qualification and config clamping
   always_comb begin
      rise     = ga_enable & ~en_q;
      fall     = ~ga_enable & en_q;
      full_now = (o_fullness == b_q);
      wr_acc   = i_valid_pls & ga_enable & o_ready;
      drop     = i_valid_pls & ga_enable & ~mode_q & full_now;
      rd       = rd_req & ga_enable;
      rd_err   = (rd_idx >= o_fullness);
      m_clamp  = (cnfg_m > M_MAX_W'(M_MAX)) ? M_MAX_W'(M_MAX) : cnfg_m;
      if (cnfg_b == '0)                    b_clamp = B_MAX_W'(1);
      else if (cnfg_b > B_MAX_W'(B_MAX))   b_clamp = B_MAX_W'(B_MAX);
      else                                 b_clamp = cnfg_b;
      m_n    = rise ? m_clamp   : m_q;
      b_n    = rise ? b_clamp   : b_q;
      mode_n = rise ? cnfg_mode : mode_q;
   end

   // Zero out channels at or above the active channel count
   always_comb begin
      wr_vec = '0;
      for (int k = 0; k < M_MAX; k++) begin
         if (M_MAX_W'(k) < m_q) wr_vec[k*DATA_W +: DATA_W] = i_v_vec_flat[k*DATA_W +: DATA_W];
      end
   end

   // Physical slot of a logical read index, wrapped at the latched depth
   always_comb begin
      slot_sum = SUM_W'(oldest) + SUM_W'(rd_idx);
      if (slot_sum >= SUM_W'(b_q)) slot_sum = slot_sum - SUM_W'(b_q);
      slot = PTR_W'(slot_sum);
   end

   // Next pointer / fullness state for an accepted write
   always_comb begin
      wr_ptr_n   = wr_ptr;
      oldest_n   = oldest;
      fullness_n = o_fullness;
      if (wr_acc) begin
         wr_ptr_n = (B_MAX_W'(wr_ptr) == b_q - 1'b1) ? '0 : wr_ptr + 1'b1;
         if (full_now) oldest_n   = (B_MAX_W'(oldest) == b_q - 1'b1) ? '0 : oldest + 1'b1;
         else          fullness_n = o_fullness + 1'b1;
      end
      full_n  = (fullness_n == b_n);
      ready_n = ga_enable & (mode_n | ~full_n);
   end

   // Sample storage; contents survive reset, fullness guards stale slots
   always_ff @(posedge clk) begin
      if (wr_acc && !sw_rst) begin
         mem_v[wr_ptr] <= wr_vec;
         mem_d[wr_ptr] <= i_d;
      end
   end

   // Control, status, counters and registered read port
   always_ff @(posedge clk) begin
      if (sw_rst) begin
         en_q           <= 1'b0;
         m_q            <= '0;
         b_q            <= B_MAX_W'(1);
         mode_q         <= 1'b0;
         wr_ptr         <= '0;
         oldest         <= '0;
         o_fullness     <= '0;
         o_full         <= 1'b0;
         o_empty        <= 1'b1;
         o_ready        <= 1'b0;
         o_wr_counter   <= '0;
         o_drop_counter <= '0;
         o_rd_valid     <= 1'b0;
         o_rd_err       <= 1'b0;
         o_v_vec_flat   <= '0;
         o_d            <= '0;
      end else begin
         en_q    <= ga_enable;
         m_q     <= m_n;
         b_q     <= b_n;
         mode_q  <= mode_n;
         o_ready <= ready_n;
         if (fall) begin
            wr_ptr         <= '0;
            oldest         <= '0;
            o_fullness     <= '0;
            o_full         <= 1'b0;
            o_empty        <= 1'b1;
            o_wr_counter   <= '0;
            o_drop_counter <= '0;
         end else begin
            wr_ptr     <= wr_ptr_n;
            oldest     <= oldest_n;
            o_fullness <= fullness_n;
            o_full     <= full_n;
            o_empty    <= (fullness_n == '0);
            if (wr_acc && (o_wr_counter != '1))   o_wr_counter   <= o_wr_counter + 1'b1;
            if (drop && (o_drop_counter != '1))   o_drop_counter <= o_drop_counter + 1'b1;
         end
         o_rd_valid <= rd;
         o_rd_err   <= rd & rd_err;
         if (rd) begin
            o_v_vec_flat <= rd_err ? '0 : mem_v[slot];
            o_d          <= rd_err ? '0 : mem_d[slot];
         end
      end
   end

endmodule

// File: tb/tb_ga_vd_window_buff.sv
// tb_ga_vd_window_buff: randomized + directed bench with a queue-based window model and read scoreboard.
module tb_ga_vd_window_buff;

   localparam int DATA_W  = 32;
   localparam int M_MAX   = 8;
   localparam int B_MAX   = 16;
   localparam int M_MAX_W = $clog2(M_MAX + 1);
   localparam int B_MAX_W = $clog2(B_MAX + 1);
   localparam int VEC_W   = DATA_W * M_MAX;

   logic                clk = 1'b0;
   logic                sw_rst = 1'b0;
   logic                ga_enable = 1'b0;
   logic [M_MAX_W-1:0]  cnfg_m = '0;
   logic [B_MAX_W-1:0]  cnfg_b = '0;
   logic                cnfg_mode = 1'b0;
   logic                i_valid_pls = 1'b0;
   logic [VEC_W-1:0]    i_v_vec_flat = '0;
   logic [DATA_W-1:0]   i_d = '0;
   logic                rd_req = 1'b0;
   logic [B_MAX_W-1:0]  rd_idx = '0;
   logic                o_rd_valid, o_rd_err, o_ready, o_full, o_empty;
   logic [VEC_W-1:0]    o_v_vec_flat;
   logic [DATA_W-1:0]   o_d;
   logic [B_MAX_W-1:0]  o_fullness;
   logic [31:0]         o_wr_counter, o_drop_counter;

   ga_vd_window_buff #(.DATA_W(DATA_W), .M_MAX(M_MAX), .B_MAX(B_MAX)) dut (
      .clk(clk), .sw_rst(sw_rst), .ga_enable(ga_enable),
      .cnfg_m(cnfg_m), .cnfg_b(cnfg_b), .cnfg_mode(cnfg_mode),
      .i_valid_pls(i_valid_pls), .i_v_vec_flat(i_v_vec_flat), .i_d(i_d),
      .rd_req(rd_req), .rd_idx(rd_idx),
      .o_rd_valid(o_rd_valid), .o_v_vec_flat(o_v_vec_flat), .o_d(o_d), .o_rd_err(o_rd_err),
      .o_ready(o_ready), .o_full(o_full), .o_empty(o_empty), .o_fullness(o_fullness),
      .o_wr_counter(o_wr_counter), .o_drop_counter(o_drop_counter)
   );

   always #5 clk = ~clk;

   typedef struct { logic [VEC_W-1:0] v; logic [DATA_W-1:0] d; } ent_t;
   typedef struct { logic err; logic [VEC_W-1:0] v; logic [DATA_W-1:0] d; } exp_t;

   // Reference model: window as an oldest-first queue
   ent_t   win[$];
   exp_t   exp_q[$];
   int     m_m = 0, m_depth = 1;
   bit     m_mode = 0, m_en = 0;
   longint m_wr = 0, m_drop = 0;
   int     n_vec = 0, n_bad = 0;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [VEC_W-1:0] rand_vec();
      logic [VEC_W-1:0] v;
      for (int k = 0; k < M_MAX; k++) v[k*DATA_W +: DATA_W] = $urandom;
      return v;
   endfunction

   function automatic logic [VEC_W-1:0] mask_vec(input logic [VEC_W-1:0] v);
      for (int k = 0; k < M_MAX; k++) if (k >= m_m) v[k*DATA_W +: DATA_W] = '0;
      return v;
   endfunction

   task automatic check_status();
      check("fullness", 64'(o_fullness), 64'(win.size()));
      check("full", 64'(o_full), 64'(win.size() == m_depth));
      check("empty", 64'(o_empty), 64'(win.size() == 0));
      check("ready", 64'(o_ready), 64'(m_en && (m_mode || win.size() < m_depth)));
      check("wr_counter", 64'(o_wr_counter), 64'(m_wr));
      check("drop_counter", 64'(o_drop_counter), 64'(m_drop));
   endtask

   // One cycle of stimulus; the model sees the read before the write
   task automatic step(input bit wr, input logic [VEC_W-1:0] v, input logic [DATA_W-1:0] d,
                       input bit rd, input int idx);
      exp_t e;
      ent_t n;
      i_valid_pls = wr; i_v_vec_flat = v; i_d = d; rd_req = rd; rd_idx = B_MAX_W'(idx);
      if (rd && m_en) begin
         e.err = (idx >= win.size());
         if (e.err) begin e.v = '0; e.d = '0; end
         else begin e.v = win[idx].v; e.d = win[idx].d; end
         exp_q.push_back(e);
      end
      if (wr && m_en) begin
         n.v = mask_vec(v); n.d = d;
         if (win.size() < m_depth) begin win.push_back(n); m_wr++; end
         else if (m_mode) begin void'(win.pop_front()); win.push_back(n); m_wr++; end
         else m_drop++;
      end
      cycle();
      i_valid_pls = 1'b0; rd_req = 1'b0;
   endtask

   task automatic enable(input int m, input int b, input bit mode);
      cnfg_m = M_MAX_W'(m); cnfg_b = B_MAX_W'(b); cnfg_mode = mode;
      ga_enable = 1'b1;
      cycle();
      m_en = 1; m_mode = mode;
      m_m = (m > M_MAX) ? M_MAX : m;
      m_depth = (b == 0) ? 1 : ((b > B_MAX) ? B_MAX : b);
      cnfg_m = M_MAX_W'($urandom); cnfg_b = B_MAX_W'($urandom); cnfg_mode = 1'($urandom);
      check_status();
   endtask

   task automatic disable_blk();
      ga_enable = 1'b0; m_en = 0;
      cycle();
      win.delete(); m_wr = 0; m_drop = 0;
      cycle();
      check_status();
   endtask

   task automatic do_reset(input bit with_rd);
      sw_rst = 1'b1; rd_req = with_rd; rd_idx = '0;
      cycle();
      sw_rst = 1'b0; rd_req = 1'b0; ga_enable = 1'b0;
      win.delete(); m_wr = 0; m_drop = 0; m_m = 0; m_depth = 1; m_mode = 0; m_en = 0;
      check("rst_rd_valid", 64'(o_rd_valid), 64'd0);
      check("rst_rd_err", 64'(o_rd_err), 64'd0);
      check("rst_d", 64'(o_d), 64'd0);
      check("rst_vec_zero", 64'(o_v_vec_flat == '0), 64'd1);
      check_status();
      cycle();
   endtask

   // Scoreboard monitor: every presented read must match the oldest expectation
   exp_t me;
   always @(negedge clk) begin
      if (o_rd_valid) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL rd_unexpected: got o_rd_valid=1 expected no read");
         end else begin
            me = exp_q.pop_front();
            if (o_rd_err !== me.err || o_d !== me.d || o_v_vec_flat !== me.v) begin
               n_bad++;
               $display("FAIL rd_data: got err=%0b d=%0h v=%0h expected err=%0b d=%0h v=%0h",
                        o_rd_err, o_d, o_v_vec_flat, me.err, me.d, me.v);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [VEC_W-1:0] v;
      cycle();
      do_reset(0);

      // Fill-once: 6 writes into depth 4
      enable(3, 4, 0);
      for (int d = 1; d <= 6; d++) step(1, rand_vec(), DATA_W'(d), 0, 0);
      check_status();
      check("fill_fullness", 64'(o_fullness), 64'd4);
      check("fill_drop", 64'(o_drop_counter), 64'd2);
      step(0, '0, '0, 1, 0);
      step(0, '0, '0, 1, 3);
      step(0, '0, '0, 1, 4);
      disable_blk();

      // Sliding: 5 writes into depth 3
      enable(2, 3, 1);
      for (int d = 10; d <= 14; d++) step(1, rand_vec(), DATA_W'(d), 0, 0);
      check_status();
      for (int i = 0; i < 3; i++) step(0, '0, '0, 1, i);
      check("slide_drop", 64'(o_drop_counter), 64'd0);
      disable_blk();

      // Channel masking
      enable(2, 5, 0);
      for (int k = 0; k < M_MAX; k++) v[k*DATA_W +: DATA_W] = DATA_W'(32'hA + k);
      step(1, v, 32'h55, 0, 0);
      step(0, '0, '0, 1, 0);
      disable_blk();

      // Read/write collision in sliding mode
      enable(8, 2, 1);
      step(1, rand_vec(), 32'd7, 0, 0);
      step(1, rand_vec(), 32'd8, 0, 0);
      step(1, rand_vec(), 32'd9, 1, 0);
      step(0, '0, '0, 1, 0);
      step(0, '0, '0, 1, 1);
      disable_blk();

      // Depth 0 behaves as 1, out-of-range read errors
      enable(4, 0, 0);
      step(1, rand_vec(), 32'd1, 0, 0);
      step(0, '0, '0, 1, 1);
      step(0, '0, '0, 1, 0);
      step(1, rand_vec(), 32'd2, 0, 0);
      check_status();
      disable_blk();

      // Config above maximum clamps
      enable(15, 31, 1);
      for (int i = 0; i < 20; i++) step(1, rand_vec(), DATA_W'(100 + i), 0, 0);
      check_status();
      for (int i = 0; i <= B_MAX; i++) step(0, '0, '0, 1, i);
      disable_blk();

      // Strobes while disabled are ignored
      step(1, rand_vec(), 32'd3, 1, 0);
      check_status();

      // Randomized rounds
      for (int r = 0; r < 6; r++) begin
         enable($urandom_range(0, 15), $urandom_range(0, 31), 1'($urandom));
         for (int c = 0; c < 80; c++) begin
            step(1'($urandom), rand_vec(), DATA_W'($urandom), ($urandom % 3) == 0, $urandom_range(0, 18));
            check_status();
         end
         disable_blk();
      end

      // Reset mid-operation with a read in the same cycle
      enable(3, 6, 0);
      for (int i = 0; i < 3; i++) step(1, rand_vec(), DATA_W'(i + 1), 0, 0);
      step(0, '0, '0, 1, 0);
      do_reset(1);

      // Enable drop clears state
      enable(3, 6, 1);
      for (int i = 0; i < 3; i++) step(1, rand_vec(), DATA_W'(i + 1), 0, 0);
      check_status();
      disable_blk();

      cycle(); cycle(); cycle();
      check("pending_reads", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ga_vd_window_buff.md
GA_VD_WINDOW_BUFF -- requirements
Module: ga_vd_window_buff

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample word width.
REQ-002 SHALL have parameter M_MAX, default 8, max v_vec channels.
REQ-003 SHALL have parameter B_MAX, default 16, max window depth in entries.
REQ-004 SHALL have parameters M_MAX_W = $clog2(M_MAX+1) and B_MAX_W = $clog2(B_MAX+1), derived.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; sw_rst in 1, sync active-high reset.
REQ-006 SHALL have ga_enable in 1; block active while high.
REQ-007 SHALL have cnfg_m in M_MAX_W; active channel count.
REQ-008 SHALL have cnfg_b in B_MAX_W; window depth.
REQ-009 SHALL have cnfg_mode in 1; 0 = fill-once, 1 = sliding window.
REQ-010 SHALL have i_valid_pls in 1; one-cycle write strobe.
REQ-011 SHALL have i_v_vec_flat in DATA_W*M_MAX; channel k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have i_d in DATA_W; desired sample.
REQ-013 SHALL have rd_req in 1, read strobe, and rd_idx in B_MAX_W, index relative to oldest entry.
REQ-014 SHALL have outputs o_rd_valid 1, o_v_vec_flat DATA_W*M_MAX, o_d DATA_W, and o_rd_err 1.
REQ-015 SHALL have outputs o_ready 1, o_full 1, o_empty 1, and o_fullness B_MAX_W.
REQ-016 SHALL have outputs o_wr_counter 32, accepted writes, and o_drop_counter 32, dropped writes.

Function
REQ-017 SHALL latch cnfg_m, cnfg_b and cnfg_mode on the cycle ga_enable rises; later changes to the config inputs SHALL be ignored until the next rising edge.
REQ-018 SHALL clamp the latched depth: 0 -> 1, values > B_MAX -> B_MAX. Channel count SHALL clamp to M_MAX.
REQ-019 SHALL accept a write when i_valid_pls & ga_enable & o_ready; channels k >= latched m SHALL be stored as zero.
REQ-020 SHALL wrap the write pointer at latched depth-1 -> 0, not at B_MAX-1.
REQ-021 o_fullness SHALL increment per accepted write and saturate at the latched depth; o_full = (fullness == depth); o_empty = (fullness == 0).
REQ-022 In fill-once mode, o_ready SHALL equal ~o_full & ga_enable. A write strobe while full SHALL be dropped and SHALL increment o_drop_counter.
REQ-023 In sliding mode, o_ready SHALL equal ga_enable. A write while full SHALL overwrite the oldest entry and advance the oldest pointer; fullness stays at depth, and the drop counter is unchanged.
REQ-024 A write strobe while ga_enable is low SHALL be ignored: not stored, not counted.
REQ-025 A read SHALL have 1-cycle latency: rd_req at cycle N gives o_rd_valid high for exactly cycle N+1, with data from physical slot (oldest + rd_idx) mod depth.
REQ-026 If rd_idx >= fullness, the read SHALL return zero data with o_rd_valid=1 and o_rd_err=1 for that cycle.
REQ-027 A read and a write in the same cycle SHALL be read-before-write: the read returns the contents before that cycle's write, and index resolution uses the pre-write oldest pointer and fullness.
REQ-028 rd_req while ga_enable is low SHALL produce no o_rd_valid.
REQ-029 o_v_vec_flat and o_d SHALL hold their last values while o_rd_valid is low.
REQ-030 Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-031 On the falling edge of ga_enable (registered detection, one cycle later), the block SHALL clear pointers, fullness and counters, identical to sw_rst except that the latched config is retained.

Reset
REQ-032 With sw_rst high at a clock edge, all outputs SHALL be zero next cycle, except o_empty=1.
REQ-033 sw_rst SHALL clear pointers, fullness, counters and the latched config (m=0, b=1, mode=0).
REQ-034 sw_rst SHALL cancel any read in flight.
REQ-035 sw_rst SHALL take priority over all simultaneous events.
REQ-036 Storage contents need not be cleared; an unwritten slot SHALL never be readable without o_rd_err.

Verification
REQ-037 Fill-once: m=3, b=4, write 6 samples d=1..6 -> fullness=4, o_full=1, o_ready=0, drop_counter=2; rd_idx=0 returns d=1; rd_idx=3 returns d=4.
REQ-038 Sliding: m=2, b=3, write d=10..14 -> fullness=3, oldest d=12; rd_idx 0/1/2 return 12/13/14; drop_counter=0.
REQ-039 Channel masking: m=2, input channels = 0xA,0xB,0xC,... -> read returns channels 0xA,0xB, and all other channels are 0.
REQ-040 Read/write collision: sliding, b=2, full with d=7,8; a write of d=9 and rd_idx=0 in the same cycle -> returns d=7; the next read of idx 0 returns d=8.
REQ-041 Error/boundary: after 1 write, rd_idx=1 -> o_rd_valid=1, o_rd_err=1, data=0. With cnfg_b=0, the depth behaves as 1.
REQ-042 Reset mid-operation: 3 writes then sw_rst asserted together with a rd_req -> no o_rd_valid, fullness=0, o_empty=1, counters=0. A ga_enable drop clears the same state but keeps the config.
